// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and clamp helper for the score keeper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX          = 4'd9;
  localparam int         MAX_SCORE_DIGITS = 8;

  // Out-of-range BCD codes from the game FSM are read as the largest digit.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of a ripple add/subtract; carry_in/out doubles as borrow in subtract mode.
// Latency: purely combinational.
// Backpressure: none, always accepts its operands.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic       sub_mode,
  input  bcd_digit_t a_dig,
  input  bcd_digit_t b_dig,
  input  logic       carry_in,
  output bcd_digit_t y_dig,
  output logic       carry_out
);

  logic [4:0] sum_raw;
  logic [4:0] diff_raw;

  // Binary add/subtract, then decimal-correct by +/-10 when the digit leaves 0..9.
  always_comb begin
    sum_raw   = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_in};
    diff_raw  = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, carry_in};
    y_dig     = '0;
    carry_out = 1'b0;
    if (sub_mode) begin
      if (diff_raw[4]) begin
        y_dig     = diff_raw[3:0] + 4'd10;
        carry_out = 1'b1;
      end else begin
        y_dig     = diff_raw[3:0];
      end
    end else begin
      if (sum_raw > 5'd9) begin
        y_dig     = sum_raw[3:0] - 4'd10;
        carry_out = 1'b1;
      end else begin
        y_dig     = sum_raw[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Packed-BCD score with same-cycle bonus/penalty, sticky overflow and session high score.
// Latency: strobe at edge k shows on score_bcd after edge k; high_bcd lags score by one more edge.
// Backpressure: none, every strobe is consumed on the cycle it is presented.
module bcd_score_keeper
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    hi_clear,
  input  logic                    add_valid,
  input  logic [3:0]              add_value,
  input  logic                    sub_valid,
  input  logic [3:0]              sub_value,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    overflow,
  output logic                    new_high
);

  localparam int             W         = 4 * NUM_DIGITS;
  localparam logic [W-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0]      score_q, score_d;
  logic [W-1:0]      high_q, high_d;
  logic              overflow_q, overflow_d;
  logic              new_high_q, new_high_d;

  bcd_digit_t        add_term, sub_term, delta_mag;
  logic              do_add, do_sub;
  logic [W-1:0]      operand;
  logic [W-1:0]      chain_y;
  logic [NUM_DIGITS:0] chain_c;

  // Net the two strobes into a single magnitude and direction for the ripple chain.
  always_comb begin
    add_term  = add_valid ? bcd_clamp(add_value) : '0;
    sub_term  = sub_valid ? bcd_clamp(sub_value) : '0;
    do_add    = (add_term > sub_term);
    do_sub    = (sub_term > add_term);
    delta_mag = do_add ? (add_term - sub_term) : (sub_term - add_term);
    operand      = '0;
    operand[3:0] = delta_mag;
  end

  assign chain_c[0] = 1'b0;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_addsub u_digit (
      .sub_mode  (do_sub),
      .a_dig     (score_q[4*i +: 4]),
      .b_dig     (operand[4*i +: 4]),
      .carry_in  (chain_c[i]),
      .y_dig     (chain_y[4*i +: 4]),
      .carry_out (chain_c[i+1])
    );
  end

  // Score next state: clear first, then overflow handling on add, zero floor on subtract.
  always_comb begin
    score_d    = score_q;
    overflow_d = overflow_q;
    if (clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (do_add) begin
      if (chain_c[NUM_DIGITS]) begin
        overflow_d = 1'b1;
        score_d    = SATURATE ? ALL_NINES : chain_y;
      end else begin
        score_d    = chain_y;
      end
    end else if (do_sub) begin
      score_d = chain_c[NUM_DIGITS] ? '0 : chain_y;
    end
  end

  // High score follows the registered score; packed BCD orders the same as plain unsigned.
  always_comb begin
    high_d     = high_q;
    new_high_d = 1'b0;
    if (hi_clear) begin
      high_d = '0;
    end else if (score_q > high_q) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
  end

  // State registers; reset discards any strobe in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q    <= '0;
      high_q     <= '0;
      overflow_q <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      overflow_q <= overflow_d;
      new_high_q <= new_high_d;
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign overflow  = overflow_q;
  assign new_high  = new_high_q;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Directed checks of bcd_score_keeper: 3-digit saturating plus 2-digit saturating/wrapping variants.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// No backpressure involved.
module tb_bcd_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, hi_clear, add_valid, sub_valid;
  logic [3:0]  add_value, sub_value;

  logic [11:0] score3, high3;
  logic        ovf3, nh3;
  logic [7:0]  score2s, high2s, score2w, high2w;
  logic        ovf2s, nh2s, ovf2w, nh2w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_score_keeper #(.NUM_DIGITS(3), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hi_clear(hi_clear),
    .add_valid(add_valid), .add_value(add_value),
    .sub_valid(sub_valid), .sub_value(sub_value),
    .score_bcd(score3), .high_bcd(high3), .overflow(ovf3), .new_high(nh3)
  );

  bcd_score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b1)) dut_2sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hi_clear(hi_clear),
    .add_valid(add_valid), .add_value(add_value),
    .sub_valid(sub_valid), .sub_value(sub_value),
    .score_bcd(score2s), .high_bcd(high2s), .overflow(ovf2s), .new_high(nh2s)
  );

  bcd_score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b0)) dut_2wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hi_clear(hi_clear),
    .add_valid(add_valid), .add_value(add_value),
    .sub_valid(sub_valid), .sub_value(sub_value),
    .score_bcd(score2w), .high_bcd(high2w), .overflow(ovf2w), .new_high(nh2w)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive strobes after a falling edge, return on the next falling edge.
  task automatic cyc(input logic av, input logic [3:0] aval, input logic sv, input logic [3:0] sval,
                     input logic clr, input logic hclr);
    add_valid = av;  add_value = aval;
    sub_valid = sv;  sub_value = sval;
    clear     = clr; hi_clear  = hclr;
    @(negedge clk);
    add_valid = 1'b0; add_value = 4'd0;
    sub_valid = 1'b0; sub_value = 4'd0;
    clear     = 1'b0; hi_clear  = 1'b0;
  endtask

  task automatic add_n(input int n, input logic [3:0] v);
    for (int k = 0; k < n; k++) cyc(1'b1, v, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; hi_clear = 1'b0;
    add_valid = 1'b0; add_value = 4'd0;
    sub_valid = 1'b0; sub_value = 4'd0;
    @(negedge clk);
    check_val("rst_score", 32'(score3), 32'h000);
    check_val("rst_high",  32'(high3),  32'h000);
    check_val("rst_ovf",   32'(ovf3),   32'd0);
    check_val("rst_nh",    32'(nh3),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two bonuses of 7, high follows one cycle behind
    cyc(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("t1_score7", 32'(score3), 32'h007);
    check_val("t1_nh_a0",  32'(nh3),    32'd0);
    cyc(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("t1_score14", 32'(score3), 32'h014);
    check_val("t1_high7",   32'(high3),  32'h007);
    check_val("t1_nh_a",    32'(nh3),    32'd1);
    idle();
    check_val("t1_high14",  32'(high3),  32'h014);
    check_val("t1_nh_b",    32'(nh3),    32'd1);
    check_val("t1_ovf",     32'(ovf3),   32'd0);
    idle();
    check_val("t1_nh_off",  32'(nh3),    32'd0);

    // 2: penalty floors at zero, out-of-range values clamp to 9
    do_reset();
    add_n(1, 4'd3);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    check_val("t2_floor",   32'(score3), 32'h000);
    check_val("t2_ovf",     32'(ovf3),   32'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    check_val("t2_at_zero", 32'(score3), 32'h000);
    cyc(1'b1, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("t2_clamp_add", 32'(score3), 32'h009);
    cyc(1'b0, 4'd0, 1'b1, 4'hC, 1'b0, 1'b0);
    check_val("t2_clamp_sub", 32'(score3), 32'h000);

    // 3: reach 95 then add 9 on all three widths/modes
    do_reset();
    add_n(10, 4'd9);
    add_n(1, 4'd5);
    check_val("t3_pre_2s", 32'(score2s), 32'h95);
    check_val("t3_pre_3",  32'(score3),  32'h095);
    add_n(1, 4'd9);
    check_val("t3_sat_score",  32'(score2s), 32'h99);
    check_val("t3_sat_ovf",    32'(ovf2s),   32'd1);
    check_val("t3_wrap_score", 32'(score2w), 32'h04);
    check_val("t3_wrap_ovf",   32'(ovf2w),   32'd1);
    check_val("t3_3dig_score", 32'(score3),  32'h104);
    check_val("t3_3dig_ovf",   32'(ovf3),    32'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
    check_val("t3_sticky_2s",  32'(ovf2s),   32'd1);
    check_val("t3_sub_2s",     32'(score2s), 32'h98);
    check_val("t3_sub_2w",     32'(score2w), 32'h03);
    check_val("t3_borrow_3",   32'(score3),  32'h103);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_val("t3_clr_ovf_2s", 32'(ovf2s),   32'd0);
    check_val("t3_clr_ovf_2w", 32'(ovf2w),   32'd0);
    check_val("t3_clr_high",   32'(high3),   32'h104);

    // 4: simultaneous bonus and penalty
    do_reset();
    add_n(1, 4'd9);
    add_n(1, 4'd1);
    check_val("t4_ten", 32'(score3), 32'h010);
    cyc(1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 1'b0);
    check_val("t4_net2", 32'(score3), 32'h012);
    cyc(1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0);
    check_val("t4_net0", 32'(score3), 32'h012);
    cyc(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0);
    check_val("t4_net_m9", 32'(score3), 32'h003);

    // 5: clear beats add, high survives; hi_clear zeroes high
    do_reset();
    add_n(5, 4'd9);
    add_n(1, 4'd5);
    idle();
    check_val("t5_high50", 32'(high3), 32'h050);
    cyc(1'b1, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
    check_val("t5_clr_score", 32'(score3), 32'h000);
    check_val("t5_clr_ovf",   32'(ovf3),   32'd0);
    check_val("t5_clr_high",  32'(high3),  32'h050);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    check_val("t5_hiclr",     32'(high3),  32'h000);
    check_val("t5_hiclr_nh",  32'(nh3),    32'd0);

    // 6: asynchronous reset between edges, then bonus on the first edge after release
    do_reset();
    add_n(13, 4'd9);
    add_n(1, 4'd6);
    check_val("t6_pre", 32'(score3), 32'h123);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_score", 32'(score3), 32'h000);
    check_val("t6_async_high",  32'(high3),  32'h000);
    check_val("t6_async_ovf",   32'(ovf3),   32'd0);
    check_val("t6_async_nh",    32'(nh3),    32'd0);
    #1;
    add_valid = 1'b1; add_value = 4'd4;
    rst_n = 1'b1;
    @(negedge clk);
    add_valid = 1'b0; add_value = 4'd0;
    check_val("t6_post_add", 32'(score3), 32'h004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
